// File: rtl/qspi_rx_pack_fifo.sv
// RX FIFO for the QSPI datapath: packs IN_W-bit items little-endian into
// WIDTH-bit words with a valid-lane count, and presents the head word show-ahead.
module qspi_rx_pack_fifo #(
  parameter int IN_W  = 8,
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int RATIO = WIDTH / IN_W,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(RATIO) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [IN_W-1:0]  wr_data_i,
  input  logic             wr_last_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [CW-1:0]    rd_bytes_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [AW:0]      level_o,
  input  logic [AW:0]      afull_thresh_i,
  output logic             afull_o,
  output logic             pack_busy_o,
  output logic             overflow_o,
  output logic             underflow_o,
  input  logic             clr_err_i
);

  localparam int LW = CW - 1;
  localparam logic [LW-1:0] LAST_IDX = LW'(RATIO - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  typedef struct packed {
    logic [CW-1:0]    bytes;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [LW-1:0]    r_idx;
  logic [WIDTH-1:0] r_pack;
  logic             r_overflow;
  logic             r_underflow;

  logic [WIDTH-1:0] w_pack_next;
  logic             w_commit;
  logic             w_push;
  logic             w_pop;
  logic             w_ovf_evt;
  logic             w_udf_evt;
  logic             w_full;
  logic             w_empty;
  entry_t           w_head;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  // Lanes above r_idx are always zero because the packer is cleared on every
  // commit, drop and flush, so the committed word needs no extra masking.
  always_comb begin
    w_pack_next = r_pack;
    w_pack_next[r_idx*IN_W +: IN_W] = wr_data_i;
  end

  // Flush overrides every same-cycle event, including the error flags.
  assign w_commit  = wr_en_i && ((r_idx == LAST_IDX) || wr_last_i) && !flush_i;
  assign w_push    = w_commit && !w_full;
  assign w_ovf_evt = w_commit && w_full;
  assign w_pop     = rd_en_i && !w_empty && !flush_i;
  assign w_udf_evt = rd_en_i && w_empty && !flush_i;

  // NOTE: the storage array has no reset; empty_o masks stale contents, and
  // keeping it out of the reset tree lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{bytes: CW'(r_idx) + CW'(1), data: w_pack_next};
    end
  end

  // Packer lane index and partial-word register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_idx  <= '0;
      r_pack <= '0;
    end else if (flush_i || w_commit) begin
      r_idx  <= '0;
      r_pack <= '0;
    end else if (wr_en_i) begin
      r_idx  <= r_idx + LW'(1);
      r_pack <= w_pack_next;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_evt)      r_overflow <= 1'b1;
      else if (clr_err_i) r_overflow <= 1'b0;
      if (w_udf_evt)      r_underflow <= 1'b1;
      else if (clr_err_i) r_underflow <= 1'b0;
    end
  end

  assign w_head      = r_mem[r_rd_ptr];
  assign rd_data_o   = w_empty ? '0 : w_head.data;
  assign rd_bytes_o  = w_empty ? '0 : w_head.bytes;
  assign empty_o     = w_empty;
  assign full_o      = w_full;
  assign level_o     = r_count;
  assign afull_o     = (r_count >= afull_thresh_i);
  assign pack_busy_o = (r_idx != '0);
  assign overflow_o  = r_overflow;
  assign underflow_o = r_underflow;

endmodule

// File: tb/tb_qspi_rx_pack_fifo.sv
// Directed self-checking bench for qspi_rx_pack_fifo (IN_W=8, WIDTH=32, DEPTH=16).
module tb_qspi_rx_pack_fifo;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush_i;
  logic        wr_en_i;
  logic [7:0]  wr_data_i;
  logic        wr_last_i;
  logic        rd_en_i;
  logic [31:0] rd_data_o;
  logic [2:0]  rd_bytes_o;
  logic        empty_o;
  logic        full_o;
  logic [4:0]  level_o;
  logic [4:0]  afull_thresh_i;
  logic        afull_o;
  logic        pack_busy_o;
  logic        overflow_o;
  logic        underflow_o;
  logic        clr_err_i;

  int n_total = 0;
  int n_bad   = 0;

  qspi_rx_pack_fifo #(.IN_W(8), .WIDTH(32), .DEPTH(16)) u_dut (
    .clk            (clk),
    .resetn         (resetn),
    .flush_i        (flush_i),
    .wr_en_i        (wr_en_i),
    .wr_data_i      (wr_data_i),
    .wr_last_i      (wr_last_i),
    .rd_en_i        (rd_en_i),
    .rd_data_o      (rd_data_o),
    .rd_bytes_o     (rd_bytes_o),
    .empty_o        (empty_o),
    .full_o         (full_o),
    .level_o        (level_o),
    .afull_thresh_i (afull_thresh_i),
    .afull_o        (afull_o),
    .pack_busy_o    (pack_busy_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o),
    .clr_err_i      (clr_err_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] d, input logic last, input logic rd);
    wr_en_i   = 1'b1;
    wr_data_i = d;
    wr_last_i = last;
    rd_en_i   = rd;
    step();
    wr_en_i   = 1'b0;
    wr_last_i = 1'b0;
    rd_en_i   = 1'b0;
  endtask

  task automatic pop();
    rd_en_i = 1'b1;
    step();
    rd_en_i = 1'b0;
  endtask

  function automatic logic [31:0] fill_word(input int i);
    logic [7:0] b = 8'(i * 16);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  task automatic put_fill_word(input int i);
    logic [31:0] w = fill_word(i);
    for (int k = 0; k < 4; k++) put(w[k*8 +: 8], 1'b0, 1'b0);
  endtask

  initial begin
    resetn = 1'b0; flush_i = 1'b0; wr_en_i = 1'b0; wr_data_i = '0;
    wr_last_i = 1'b0; rd_en_i = 1'b0; afull_thresh_i = 5'd16; clr_err_i = 1'b0;
    #12;
    check("rst_empty", empty_o, 1);
    check("rst_level", level_o, 0);
    check("rst_data",  rd_data_o, 0);
    resetn = 1'b1;
    step();

    // 1: full word of four items
    put(8'h11, 1'b0, 1'b0);
    check("t1_busy_partial", pack_busy_o, 1);
    check("t1_empty_partial", empty_o, 1);
    put(8'h22, 1'b0, 1'b0);
    put(8'h33, 1'b0, 1'b0);
    put(8'h44, 1'b0, 1'b0);
    check("t1_empty", empty_o, 0);
    check("t1_data", rd_data_o, 32'h4433_2211);
    check("t1_bytes", rd_bytes_o, 4);
    check("t1_level", level_o, 1);
    check("t1_busy", pack_busy_o, 0);
    pop();

    // 2: partial word ended by wr_last_i
    put(8'hAA, 1'b0, 1'b0);
    put(8'hBB, 1'b1, 1'b0);
    check("t2_data", rd_data_o, 32'h0000_BBAA);
    check("t2_bytes", rd_bytes_o, 2);
    pop();
    check("t2_empty", empty_o, 1);
    check("t2_data0", rd_data_o, 0);
    check("t2_bytes0", rd_bytes_o, 0);

    // 3: fill, overflow drop, drop with simultaneous pop, drain in order
    for (int i = 0; i < 16; i++) put_fill_word(i);
    check("t3_full", full_o, 1);
    check("t3_level16", level_o, 16);
    put(8'hE0, 1'b0, 1'b0);
    check("t3_busy_accept", pack_busy_o, 1);
    put(8'hE1, 1'b0, 1'b0);
    put(8'hE2, 1'b0, 1'b0);
    put(8'hE3, 1'b0, 1'b0);
    check("t3_ovf", overflow_o, 1);
    check("t3_level_drop", level_o, 16);
    check("t3_idx0", pack_busy_o, 0);
    check("t3_head_kept", rd_data_o, fill_word(0));
    put(8'hE4, 1'b1, 1'b1);
    check("t3_level_pop_drop", level_o, 15);
    for (int i = 1; i < 16; i++) begin
      check($sformatf("t3_data%0d", i), rd_data_o, fill_word(i));
      pop();
    end
    check("t3_drained", empty_o, 1);
    clr_err_i = 1'b1;
    step();
    clr_err_i = 1'b0;
    check("t3_clr", overflow_o, 0);

    // 4: underflow, clear-vs-event priority, commit+pop at level 3
    pop();
    check("t4_udf", underflow_o, 1);
    check("t4_level", level_o, 0);
    rd_en_i = 1'b1; clr_err_i = 1'b1;
    step();
    rd_en_i = 1'b0; clr_err_i = 1'b0;
    check("t4_udf_wins", underflow_o, 1);
    put(8'hC1, 1'b1, 1'b0);
    put(8'hC2, 1'b1, 1'b0);
    put(8'hC3, 1'b1, 1'b0);
    check("t4_wrap_data", rd_data_o, 32'h0000_00C1);
    check("t4_wrap_bytes", rd_bytes_o, 1);
    put(8'hC4, 1'b1, 1'b1);
    check("t4_level_same", level_o, 3);
    check("t4_head_next", rd_data_o, 32'h0000_00C2);

    // 5: flush beats a same-cycle commit and pop
    clr_err_i = 1'b1;
    step();
    clr_err_i = 1'b0;
    put(8'hC5, 1'b1, 1'b0);
    put(8'hC6, 1'b1, 1'b0);
    put(8'hD0, 1'b0, 1'b0);
    put(8'hD1, 1'b0, 1'b0);
    put(8'hD2, 1'b0, 1'b0);
    check("t5_busy", pack_busy_o, 1);
    check("t5_level5", level_o, 5);
    flush_i = 1'b1;
    put(8'hD3, 1'b1, 1'b1);
    flush_i = 1'b0;
    check("t5_level", level_o, 0);
    check("t5_empty", empty_o, 1);
    check("t5_busy0", pack_busy_o, 0);
    check("t5_ovf", overflow_o, 0);
    check("t5_udf", underflow_o, 0);
    check("t5_data", rd_data_o, 0);

    // 6: almost-full threshold, threshold 0, asynchronous reset
    afull_thresh_i = 5'd4;
    for (int i = 0; i < 3; i++) put(8'(i), 1'b1, 1'b0);
    check("t6_afull_3", afull_o, 0);
    put(8'h03, 1'b1, 1'b0);
    check("t6_afull_4", afull_o, 1);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    afull_thresh_i = 5'd0;
    #1;
    check("t6_afull_t0", afull_o, 1);
    pop();
    put(8'h55, 1'b1, 1'b0);
    put(8'h66, 1'b0, 1'b0);
    check("t6_pre_udf", underflow_o, 1);
    check("t6_pre_busy", pack_busy_o, 1);
    #2;
    resetn = 1'b0;
    #1;
    check("t6_rst_empty", empty_o, 1);
    check("t6_rst_full", full_o, 0);
    check("t6_rst_level", level_o, 0);
    check("t6_rst_busy", pack_busy_o, 0);
    check("t6_rst_data", rd_data_o, 0);
    check("t6_rst_bytes", rd_bytes_o, 0);
    check("t6_rst_udf", underflow_o, 0);
    check("t6_rst_ovf", overflow_o, 0);
    check("t6_rst_afull", afull_o, 1);
    resetn = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/qspi_rx_pack_fifo.md
Name: qspi_rx_pack_fifo

Overview:
- Next-generation RX FIFO for the QSPI controller datapath.
- Accepts narrow items from the shift engine (IN_W bits, typically one byte per QSPI beat) and packs them little-endian into WIDTH-bit words.
- Stores each word with a valid-lane count, and presents words show-ahead to the bus-side read logic.
- Adds over the previous FIFO: end-of-transfer partial-word commit, flush, programmable almost-full, and sticky overflow/underflow flags.

Parameters:
- IN_W, 8: write item width in bits.
- WIDTH, 32: read word width in bits; must be a multiple of IN_W, with RATIO = WIDTH/IN_W >= 2 and a power of 2.
- DEPTH, 16: FIFO depth in words; power of 2, >= 2.
- Derived: AW = $clog2(DEPTH); CW = $clog2(RATIO)+1.

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous clear of FIFO and packer contents
- wr_en_i  in  1  write item strobe
- wr_data_i  in  IN_W  write item
- wr_last_i  in  1  item is last of transfer; qualified by wr_en_i
- rd_en_i  in  1  pop head word
- rd_data_o  out  WIDTH  head word; show-ahead
- rd_bytes_o  out  CW  valid lanes in head word, range 1..RATIO
- empty_o  out  1  no committed words
- full_o  out  1  DEPTH committed words
- level_o  out  AW+1  committed word count
- afull_thresh_i  in  AW+1  almost-full threshold
- afull_o  out  1  level_o >= afull_thresh_i
- pack_busy_o  out  1  packer holds a partial word
- overflow_o  out  1  sticky overflow flag
- underflow_o  out  1  sticky underflow flag
- clr_err_i  in  1  clear sticky flags

Behaviour:
- Reset (resetn low, asynchronous):
  - pointers, count, lane index and packer register go to 0; both sticky flags go to 0.
  - Resulting outputs: empty_o=1, full_o=0, level_o=0, pack_busy_o=0, rd_data_o=0, rd_bytes_o=0.
  - afull_o follows its equation (1 if threshold 0).
  - Memory array is not reset.
- Packer:
  - On each accepted item, wr_data_i is written to lane idx, bits [idx*IN_W +: IN_W]; lane 0 is the LSB.
  - Commit happens when idx==RATIO-1 or wr_last_i=1. The word (lanes above idx are zero) and count idx+1 are written to mem[wr_ptr] at the same edge; wr_ptr+1, idx returns to 0.
  - With no commit, idx+1.
  - pack_busy_o = (idx != 0).
- Commit latency: a word is visible on rd_data_o and empty_o deasserts the cycle after the committing edge.
- Full at commit:
  - full_o is evaluated before the edge; a simultaneous pop does not make room.
  - The whole packed word, including the current item, is discarded, idx returns to 0, and overflow_o is set.
  - Non-committing items are always accepted into the packer.
- Read:
  - rd_data_o/rd_bytes_o = mem[rd_ptr] when !empty_o; forced to 0 when empty.
  - rd_en_i && !empty_o: rd_ptr+1 at the edge; the next word is shown in the following cycle.
  - rd_en_i && empty_o: ignored, and underflow_o is set.
- Count:
  - Commit only: +1. Pop only: -1. Both: unchanged.
  - Pointers are AW bits and wrap modulo DEPTH.
  - full_o = (count==DEPTH); empty_o = (count==0); level_o = count.
- afull_o is combinational from count and afull_thresh_i.
- Flush:
  - flush_i=1 clears pointers, count and idx at the edge.
  - It overrides any same-cycle write, commit or pop; those events set no flags.
  - Sticky flags are unaffected by flush.
- clr_err_i clears both sticky flags; a same-cycle new error event wins and leaves the flag at 1.
- Width rule: the count field stored alongside each word is CW bits; memory entry width = WIDTH+CW.

Test Plan:
1. RATIO=4: write 0x11, 0x22, 0x33, 0x44, no last -> one cycle later empty_o=0, rd_data_o=0x44332211, rd_bytes_o=4, level_o=1, pack_busy_o=0.
2. Write 0xAA, then 0xBB with wr_last_i -> rd_data_o=0x0000BBAA, rd_bytes_o=2; pop -> empty_o=1, rd_data_o=0.
3. Fill 16 words -> full_o=1; commit a 17th word -> dropped, overflow_o=1, level_o=16, idx=0. Pop all 16 -> data in order and pointer wrap verified. clr_err_i -> overflow_o=0.
4. rd_en_i while empty -> underflow_o=1, level_o stays 0. Then commit and pop in the same cycle at level 3 -> level_o stays 3.
5. Three items buffered (pack_busy_o=1), level 5, flush_i together with a commit and a pop -> level_o=0, empty_o=1, pack_busy_o=0, no flag set.
6. afull_thresh_i=4: levels 3->4 -> afull_o 0->1. Threshold 0 -> afull_o=1 while empty. Assert resetn low mid-stream -> all outputs return to reset values immediately.
